// File: rtl/imm_operand_stage.sv
// Decode-to-execute operand stage: immediate extension, operand-B select, two-entry skid buffer.
// Latency: one cycle from an accepted input to the outputs when empty; throughput 1 entry/cycle.
// Backpressure: in_ready is a registered decode (low only when both entries are held), independent of out_ready.
// Optional feature macro: SIGN_EXT_EN (honour in_ext_sign for sign extension of the immediate).
module imm_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic              in_alusrc,
  input  logic              in_ext_sign,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_opa,
  output logic [DATA_W-1:0] out_opb,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] opb_next;

  logic [DATA_W-1:0] main_opa_q, main_opb_q, skid_opa_q, skid_opb_q;
  logic [DEST_W-1:0] main_dest_q, skid_dest_q;

  logic in_xfer, out_xfer;
  logic ld_main_in, ld_skid_in, ld_main_skid;

`ifdef SIGN_EXT_EN
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[31:IMM_W];
`else
  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[31:IMM_W], in_ext_sign};
`endif

  // Extend the immediate and pick operand B from the incoming entry.
  always_comb begin
    imm = in_instr[IMM_W-1:0];
    ext = {{(DATA_W-IMM_W){1'b0}}, imm};
`ifdef SIGN_EXT_EN
    if (in_ext_sign) begin
      ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
`endif
    opb_next = in_alusrc ? ext : in_rt_val;
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign out_opa   = main_opa_q;
  assign out_opb   = main_opb_q;
  assign out_dest  = main_dest_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next-state and register-load selection; flush wins over any transfer.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_skid_in   = 1'b0;
    ld_main_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d    = ST_ONE;
          ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_main_in = 1'b1;
        end else if (in_xfer) begin
          state_d    = ST_FULL;
          ld_skid_in = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_d      = ST_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d      = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_skid_in   = 1'b0;
      ld_main_skid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main (output-facing) register: new entry or promoted skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_opa_q  <= '0;
      main_opb_q  <= '0;
      main_dest_q <= '0;
    end else if (ld_main_in) begin
      main_opa_q  <= in_rs_val;
      main_opb_q  <= opb_next;
      main_dest_q <= in_dest;
    end else if (ld_main_skid) begin
      main_opa_q  <= skid_opa_q;
      main_opb_q  <= skid_opb_q;
      main_dest_q <= skid_dest_q;
    end
  end

  // Skid register: catches the second entry while the ALU is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_opa_q  <= '0;
      skid_opb_q  <= '0;
      skid_dest_q <= '0;
    end else if (ld_skid_in) begin
      skid_opa_q  <= in_rs_val;
      skid_opb_q  <= opb_next;
      skid_dest_q <= in_dest;
    end
  end

endmodule

// File: tb/tb_imm_operand_stage.sv
module tb_imm_operand_stage;

  typedef struct packed {
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic        in_alusrc = 1'b0;
  logic        in_ext_sign = 1'b0;
  logic [4:0]  in_dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_opa;
  logic [31:0] out_opb;
  logic [4:0]  out_dest;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int recv   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  imm_operand_stage #(.DATA_W(32), .IMM_W(16), .DEST_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_alusrc(in_alusrc),
    .in_ext_sign(in_ext_sign), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opa(out_opa), .out_opb(out_opb), .out_dest(out_dest),
    .occupancy(occupancy)
  );

  // Reference operand B derived from the stimulus.
  function automatic logic [31:0] model_opb(input logic [31:0] instr, input logic [31:0] rt,
                                            input logic alusrc, input logic ext_sign);
    logic [31:0] e;
    e = {16'h0000, instr[15:0]};
`ifdef SIGN_EXT_EN
    if (ext_sign && instr[15]) e = {16'hFFFF, instr[15:0]};
`endif
    if (alusrc) return e;
    return rt;
  endfunction

  task automatic set_entry(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                           input logic alusrc, input logic ext_sign, input logic [4:0] dest);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs_val   = rs;
    in_rt_val   = rt;
    in_alusrc   = alusrc;
    in_ext_sign = ext_sign;
    in_dest     = dest;
  endtask

  // One clock: handshakes are evaluated at the falling edge with the inputs held stable,
  // then the task returns 1 time unit after the next rising edge.
  task automatic cycle(output bit accepted);
    exp_t got, e;
    accepted = 1'b0;
    @(negedge clk);
    if (out_valid && out_ready) begin
      got = '{opa: out_opa, opb: out_opb, dest: out_dest};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got opa=%h opb=%h dest=%0d, required no output", got.opa, got.opb, got.dest);
      end else begin
        e = sb.pop_front();
        recv++;
        if (got !== e) begin
          errors++;
          $display("FAIL output_entry: got opa=%h opb=%h dest=%0d, required opa=%h opb=%h dest=%0d",
                   got.opa, got.opb, got.dest, e.opa, e.opb, e.dest);
        end
      end
    end
    if (flush) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      sb.push_back('{opa: in_rs_val, opb: model_opb(in_instr, in_rt_val, in_alusrc, in_ext_sign), dest: in_dest});
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle(acc);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b occ=%0d, required 0 1 0", out_valid, in_ready, occupancy);
    end
    checks++;
    if ({out_opa, out_opb, out_dest} !== 69'd0) begin
      errors++;
      $display("FAIL reset_data: got opa=%h opb=%h dest=%0d, required zeros", out_opa, out_opb, out_dest);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_imm();
    bit acc;
    logic [31:0] req;
    out_ready = 1'b1;
    set_entry(32'h2001_FFFF, 32'h10, 32'h1234_5678, 1'b1, 1'b0, 5'd3);
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_opa !== 32'h10 || out_opb !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL imm_zext: got valid=%b opa=%h opb=%h, required 1 00000010 0000ffff", out_valid, out_opa, out_opb);
    end
    cycle(acc);
`ifdef SIGN_EXT_EN
    req = 32'hFFFF_FFFF;
`else
    req = 32'h0000_FFFF;
`endif
    set_entry(32'h2001_FFFF, 32'h10, 32'h1234_5678, 1'b1, 1'b1, 5'd4);
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (out_opb !== req) begin
      errors++;
      $display("FAIL imm_ext_sign: got opb=%h, required %h", out_opb, req);
    end
    cycle(acc);
    set_entry(32'h0000_7FFF, 32'h22, 32'h0, 1'b1, 1'b1, 5'd5);
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (out_opb !== 32'h0000_7FFF) begin
      errors++;
      $display("FAIL imm_positive: got opb=%h, required 00007fff", out_opb);
    end
    drain(5);
  endtask

  task automatic test_regsel();
    bit acc;
    out_ready = 1'b1;
    set_entry(32'hFFFF_8001, 32'h55, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd9);
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (out_opb !== 32'hDEAD_BEEF || out_dest !== 5'd9) begin
      errors++;
      $display("FAIL regsel: got opb=%h dest=%0d, required deadbeef 9", out_opb, out_dest);
    end
    drain(5);
  endtask

  task automatic test_back_to_back();
    bit acc;
    int start;
    start = recv;
    out_ready = 1'b0;
    set_entry(32'h0000_00AA, 32'hA, 32'h0, 1'b1, 1'b0, 5'd10);
    cycle(acc);
    set_entry(32'h0000_00BB, 32'hB, 32'h0, 1'b1, 1'b0, 5'd11);
    cycle(acc);
    set_entry(32'h0000_00CC, 32'hC, 32'h0, 1'b1, 1'b0, 5'd12);
    cycle(acc);
    checks++;
    if (acc || occupancy !== 2'd2 || in_ready !== 1'b0 || out_dest !== 5'd10) begin
      errors++;
      $display("FAIL b2b_full: got acc=%b occ=%0d ready=%b dest=%0d, required 0 2 0 10", acc, occupancy, in_ready, out_dest);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (recv - start != 3 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got recv=%0d pending=%0d valid=%b, required 3 0 0", recv - start, sb.size(), out_valid);
    end
  endtask

  task automatic test_toggle();
    bit acc;
    int sent, start;
    sent = 0;
    start = recv;
    for (int i = 0; i < 100 && (sent < 8 || sb.size() != 0); i++) begin
      out_ready = (i % 2 == 0);
      if (sent < 8) set_entry(32'h1000_0000 + sent, 32'h100 + sent, 32'h200 + sent, sent[0], 1'b0, 5'(sent));
      else in_valid = 1'b0;
      cycle(acc);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 8 || recv - start != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_count: got sent=%0d recv=%0d pending=%0d, required 8 8 0", sent, recv - start, sb.size());
    end
  endtask

  task automatic test_flush();
    bit acc;
    out_ready = 1'b0;
    set_entry(32'h1, 32'h31, 32'h0, 1'b1, 1'b0, 5'd20);
    cycle(acc);
    set_entry(32'h2, 32'h32, 32'h0, 1'b1, 1'b0, 5'd21);
    cycle(acc);
    set_entry(32'h3, 32'h33, 32'h0, 1'b1, 1'b0, 5'd22);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got occ=%0d valid=%b ready=%b, required 0 0 1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_emit: got valid=%b after flush, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    out_ready = 1'b0;
    set_entry(32'h4, 32'h41, 32'h0, 1'b1, 1'b0, 5'd25);
    cycle(acc);
    set_entry(32'h5, 32'h42, 32'h0, 1'b1, 1'b0, 5'd26);
    cycle(acc);
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_occ: got %0d, required 2", occupancy);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b occ=%0d, required 0 1 0", out_valid, in_ready, occupancy);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_emit: got valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_regsel();
    test_back_to_back();
    test_toggle();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_operand_stage.md
Name: imm_operand_stage

Overview:
- Registered decode-to-execute operand stage for the CPU_NN datapath, placed directly upstream of the ALU.
- Pulls the immediate field out of the decoded instruction and extends it to ALU width.
- Selects ALU operand B as either the register value or the extended immediate.
- Buffers results in a two-entry skid buffer with valid/ready handshakes on both sides, so ALU stalls never drop an operand pair.

Parameters:
- DATA_W, 32, ALU operand width.
- IMM_W, 16, immediate field width (instr[IMM_W-1:0]); must be < DATA_W.
- DEST_W, 5, destination register index width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- flush, input, 1, synchronous discard of all buffered entries.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept an entry.
- in_instr, input, 32, decoded instruction word.
- in_rs_val, input, DATA_W, register-file value for operand A.
- in_rt_val, input, DATA_W, register-file value for operand B.
- in_alusrc, input, 1, 1 = operand B is the extended immediate; 0 = in_rt_val.
- in_ext_sign, input, 1, 1 = sign-extend the immediate (used only with SIGN_EXT_EN).
- in_dest, input, DEST_W, destination register index.
- out_valid, output, 1, ALU entry valid.
- out_ready, input, 1, ALU accepts the entry.
- out_opa, output, DATA_W, operand A.
- out_opb, output, DATA_W, operand B.
- out_dest, output, DEST_W, destination index.
- occupancy, output, 2, number of buffered entries (0..2).

Behaviour:
- Extension is combinational on input: imm = in_instr[IMM_W-1:0]. ext = {(DATA_W-IMM_W) zeros, imm}, except the sign-extended form defined under Optional Feature. opb_next = in_alusrc ? ext : in_rt_val.
- Transfers:
  - In-transfer occurs when in_valid && in_ready.
  - Out-transfer occurs when out_valid && out_ready.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY (occupancy 0): in-transfer -> ONE, entry loaded into main.
  - ONE (occupancy 1):
    - in-transfer only -> FULL, entry loaded into skid.
    - out-transfer only -> EMPTY.
    - both -> ONE, main reloaded with the new entry.
  - FULL (occupancy 2): out-transfer -> ONE, skid moves to main. in_ready is 0 in FULL, so there is no in-transfer.
- out_valid = (state != EMPTY).
- in_ready = (state != FULL), a registered state decode. It does not combinationally depend on out_ready.
- Latency: an entry accepted on edge N appears on the outputs after edge N when the stage was EMPTY. Throughput is 1 entry/cycle while out_ready stays high.
- Outputs hold stable while out_valid && !out_ready.
- Ordering is strictly FIFO.
- flush: on the next edge, state -> EMPTY and both registers are invalidated. flush overrides a simultaneous in-transfer and out-transfer: the out-transfer still counts downstream, and the input entry is discarded.
- Reset (async, immediate):
  - state EMPTY.
  - out_valid 0.
  - in_ready 1.
  - out_opa, out_opb, out_dest and occupancy all 0.
  - Reset mid-operation discards all buffered entries.
- Data registers load only on accepted transfers. Register contents while out_valid is 0 are don't-care, but are held at 0 after reset.

Optional Feature:
- Macro: SIGN_EXT_EN.
- Defined: when in_ext_sign = 1, ext = {(DATA_W-IMM_W) copies of imm[IMM_W-1], imm}. When in_ext_sign = 0, ext is zero-extended.
- Undefined: in_ext_sign is ignored and ext is always zero-extended. The port remains present.

Test Plan:
- Reset mid-stream with 2 entries held -> out_valid=0, in_ready=1, occupancy=0 immediately, without waiting for a clock edge.
- alusrc=1, instr=0x2001_FFFF, rs=0x10, out_ready=1 -> next cycle opa=0x10, opb=0x0000_FFFF. With SIGN_EXT_EN and ext_sign=1 -> opb=0xFFFF_FFFF.
- alusrc=0, rt=0xDEAD_BEEF -> opb=0xDEAD_BEEF regardless of the immediate.
- Back-to-back entries A, B, C with out_ready=0 -> A on outputs, B in skid, occupancy=2, in_ready=0, C held upstream. Then out_ready=1 for 3 cycles -> A, B, C emerge in order, with no loss and no duplication.
- out_ready toggling 1,0,1,0 with continuous in_valid over 8 entries (dest 0..7) -> all 8 received in order.
- flush asserted while FULL and in_valid=1 -> next cycle occupancy=0, out_valid=0, and the incoming entry is not emitted.
